// File: rtl/mmu_bus_pkg.sv
// Shared types and defaults for the 6809-style E/Q bus master.
// Holds no logic and has no latency of its own.
// Holds no logic and has no flow control of its own.
package mmu_bus_pkg;

    // Quarter-cycle phases: P0 (E=0,Q=0) P1 (E=0,Q=1) P2 (E=1,Q=1) P3 (E=1,Q=0)
    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2,
        P3 = 2'd3
    } phase_t;

    // What the bus is doing during the current E cycle
    typedef enum logic [1:0] {
        CYC_IDLE = 2'd0,
        CYC_REQ  = 2'd1,
        CYC_HOLD = 2'd2
    } cyc_t;

    // Address shown on dead cycles, as a real 6809 does
    localparam logic [15:0] IDLE_ADDR_DEF   = 16'hFFFF;
    // Longest MRDY stretch tolerated when the timeout is built
    localparam int          MAX_STRETCH_DEF = 15;

    // E and Q levels for a given phase, packed as {E, Q}
    function automatic logic [1:0] phase_eq(phase_t p);
        logic [1:0] eq;
        case (p)
            P0:      eq = 2'b00;
            P1:      eq = 2'b01;
            P2:      eq = 2'b11;
            P3:      eq = 2'b10;
            default: eq = 2'b00;
        endcase
        return eq;
    endfunction

endpackage

// File: rtl/mmu_bus_phase_gen.sv
// Phase counter, registered E/Q, MRDY stretch and cycle-boundary strobe.
// Latency: E/Q follow the phase register directly; o_boundary is combinational.
// Backpressure: MRDY low in P3 holds P3; BUS_TIMEOUT_EN adds a stretch limit.
module mmu_bus_phase_gen
    import mmu_bus_pkg::*;
#(
    parameter int MAX_STRETCH = MAX_STRETCH_DEF
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_mrdy,
    input  logic   i_ign_mrdy,
    output phase_t o_ph,
    output logic   o_e,
    output logic   o_q,
`ifdef BUS_TIMEOUT_EN
    output logic   o_timeout,
`endif
    output logic   o_boundary
);

    phase_t r_ph;
    logic   r_e;
    logic   r_q;
    phase_t w_ph_nxt;
    logic   w_p3;
    logic   w_ready;
    logic   w_timeout;
    logic   w_done;
    logic   w_stall;

    assign w_p3    = (r_ph == P3);
    // Hold cycles keep the clocks running regardless of the memory side
    assign w_ready = i_mrdy | i_ign_mrdy;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = (MAX_STRETCH < 1) ? 1 : $clog2(MAX_STRETCH + 1);

    logic [CNT_W-1:0] r_cnt;

    // A stretch that has already used its full allowance ends on this edge
    assign w_timeout = w_p3 & ~w_ready & (r_cnt == CNT_W'(MAX_STRETCH));
    assign o_timeout = w_timeout & i_rst_n;

    // Count extra P3 clocks; cleared whenever a cycle completes
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || o_boundary) begin
            r_cnt <= '0;
        end else if (w_stall) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    // Unbounded stretch: nothing to count
    assign w_timeout = 1'b0;
`endif

    assign w_done     = w_p3 & (w_ready | w_timeout);
    assign w_stall    = w_p3 & ~w_done;
    assign o_boundary = w_done & i_rst_n;

    // Next phase: advance every clock except while P3 is stretched
    always_comb begin
        w_ph_nxt = phase_t'(r_ph + 2'd1);
        if (w_stall) begin
            w_ph_nxt = P3;
        end
    end

    // Phase register with E/Q registered alongside it
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ph <= P0;
            r_e  <= 1'b0;
            r_q  <= 1'b0;
        end else begin
            r_ph       <= w_ph_nxt;
            {r_e, r_q} <= phase_eq(w_ph_nxt);
        end
    end

    assign o_ph = r_ph;
    assign o_e  = r_e;
    assign o_q  = r_q;

endmodule

// File: rtl/mmu_bus_master.sv
// 6809-style E/Q bus initiator driven from a request/response port (optional timeout: BUS_TIMEOUT_EN).
// Latency: request accepted at a cycle boundary completes 4 clocks later plus MRDY stretch; resp one clock after.
// Backpressure: req_ready only on a boundary without bus_hold; MRDY low stretches E high.
module mmu_bus_master
    import mmu_bus_pkg::*;
#(
    parameter logic [15:0] IDLE_ADDR   = IDLE_ADDR_DEF,
    parameter int          MAX_STRETCH = MAX_STRETCH_DEF
) (
    input  logic        CLKX4,
    input  logic        nRESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic        req_we,
    input  logic [7:0]  req_wdata,
    output logic        resp_valid,
    output logic [7:0]  resp_rdata,
    output logic        resp_err,
    input  logic        bus_hold,
    output logic        E,
    output logic        Q,
    output logic [15:0] ADDR,
    output logic        ADDR_oe,
    output logic        RnW,
    output logic        BA,
    output logic        BS,
    input  logic [7:0]  DATA_in,
    output logic [7:0]  DATA_out,
    output logic        DATA_oe,
    input  logic        MRDY
);

    phase_t      w_ph;
    logic        w_boundary;
    logic        w_hold_cyc;
    logic        w_resp_ff;

    cyc_t        r_cyc;
    logic        r_we;
    logic [15:0] r_addr;
    logic        r_addr_oe;
    logic        r_rnw;
    logic        r_ba;
    logic        r_bs;
    logic [7:0]  r_dout;
    logic        r_doe;
    logic        r_resp_vld;
    logic [7:0]  r_rdata;

    assign w_hold_cyc = (r_cyc == CYC_HOLD);

`ifdef BUS_TIMEOUT_EN
    logic w_timeout;
    logic r_err;
`endif

    mmu_bus_phase_gen #(
        .MAX_STRETCH (MAX_STRETCH)
    ) u_phase_gen (
        .i_clk      (CLKX4),
        .i_rst_n    (nRESET),
        .i_mrdy     (MRDY),
        .i_ign_mrdy (w_hold_cyc),
        .o_ph       (w_ph),
        .o_e        (E),
        .o_q        (Q),
`ifdef BUS_TIMEOUT_EN
        .o_timeout  (w_timeout),
`endif
        .o_boundary (w_boundary)
    );

    // A request is consumed on the boundary edge unless the bus is being handed off
    assign req_ready = w_boundary & ~bus_hold;

    // Writes and timed-out cycles return all-ones instead of bus data
`ifdef BUS_TIMEOUT_EN
    assign w_resp_ff = r_we | w_timeout;
`else
    assign w_resp_ff = r_we;
`endif

    // Latch the next cycle type and its bus drive at each boundary
    always_ff @(posedge CLKX4) begin
        if (!nRESET) begin
            r_cyc     <= CYC_IDLE;
            r_we      <= 1'b0;
            r_addr    <= IDLE_ADDR;
            r_addr_oe <= 1'b1;
            r_rnw     <= 1'b1;
            r_ba      <= 1'b0;
            r_bs      <= 1'b0;
            r_dout    <= 8'h00;
        end else if (w_boundary) begin
            if (bus_hold) begin
                // Release address/RnW; another master owns the bus
                r_cyc     <= CYC_HOLD;
                r_we      <= 1'b0;
                r_addr    <= IDLE_ADDR;
                r_addr_oe <= 1'b0;
                r_rnw     <= 1'b1;
                r_ba      <= 1'b1;
                r_bs      <= 1'b1;
            end else if (req_valid) begin
                r_cyc     <= CYC_REQ;
                r_we      <= req_we;
                r_addr    <= req_addr;
                r_addr_oe <= 1'b1;
                r_rnw     <= ~req_we;
                r_ba      <= 1'b0;
                r_bs      <= 1'b0;
                if (req_we) begin
                    r_dout <= req_wdata;
                end
            end else begin
                // Dead cycle: read from the idle address, nobody listens
                r_cyc     <= CYC_IDLE;
                r_we      <= 1'b0;
                r_addr    <= IDLE_ADDR;
                r_addr_oe <= 1'b1;
                r_rnw     <= 1'b1;
                r_ba      <= 1'b0;
                r_bs      <= 1'b0;
            end
        end
    end

    // Write data is driven from P1 until the cycle completes, stretch included
    always_ff @(posedge CLKX4) begin
        if (!nRESET) begin
            r_doe <= 1'b0;
        end else if (w_boundary) begin
            r_doe <= 1'b0;
        end else if ((r_cyc == CYC_REQ) && r_we && (w_ph == P0)) begin
            r_doe <= 1'b1;
        end
    end

    // One-clock completion pulse for request cycles, read data captured on the completing edge
    always_ff @(posedge CLKX4) begin
        if (!nRESET) begin
            r_resp_vld <= 1'b0;
            r_rdata    <= 8'h00;
        end else if (w_boundary && (r_cyc == CYC_REQ)) begin
            r_resp_vld <= 1'b1;
            r_rdata    <= w_resp_ff ? 8'hFF : DATA_in;
        end else begin
            r_resp_vld <= 1'b0;
        end
    end

`ifdef BUS_TIMEOUT_EN
    // Error flag travels with the response it belongs to
    always_ff @(posedge CLKX4) begin
        if (!nRESET) begin
            r_err <= 1'b0;
        end else if (w_boundary && (r_cyc == CYC_REQ)) begin
            r_err <= w_timeout;
        end
    end

    assign resp_err = r_err;
`else
    assign resp_err = 1'b0;
`endif

    assign ADDR       = r_addr;
    assign ADDR_oe    = r_addr_oe;
    assign RnW        = r_rnw;
    assign BA         = r_ba;
    assign BS         = r_bs;
    assign DATA_out   = r_dout;
    assign DATA_oe    = r_doe;
    assign resp_valid = r_resp_vld;
    assign resp_rdata = r_rdata;

endmodule
